// File: rtl/serial_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// serial_tx_arbiter_if
// Bundles the requester-facing signals of serial_tx_arbiter.
//   req        : per-requester frame request (level, held until granted)
//   data_in    : packed 7-bit payloads, requester i on [7i+6:7i]
//   grant      : one-hot, one-cycle pulse marking payload capture
//   src        : index of the requester owning the current/last frame
//   busy       : high from the grant cycle through the last stop cycle
//   done       : one-cycle pulse in the last stop cycle
//   serial_out : serial line, idle high
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface serial_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]   grant;
  logic [SRC_W-1:0]   src;
  logic               busy;
  logic               done;
  logic               serial_out;

  modport master (
    output req, data_in,
    input  grant, src, busy, done, serial_out
  );

  modport slave (
    input  req, data_in,
    output grant, src, busy, done, serial_out
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// ----------------------------------------------------------------------------
// serial_tx_arbiter
// Round-robin arbiter that shares one serial line among N_REQ requesters.
// Each granted requester has its 7-bit payload captured and sent as:
//   start (0), 7 data bits LSB first, odd parity, STOP_BITS high stop bits.
// Ports:
//   clk  : rising-edge clock, one serial bit per cycle
//   rstn : asynchronous active-low reset
//   bus  : serial_tx_arbiter_if.slave (req, data_in, grant, src, busy,
//          done, serial_out)
// Parameters:
//   N_REQ     : number of requesters (2..8)
//   STOP_BITS : number of stop cycles (1..4)
// ----------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rstn,
  serial_tx_arbiter_if.slave bus
);

  localparam int             SRC_W     = $clog2(N_REQ);
  localparam logic [1:0]     STOP_LAST = 2'(STOP_BITS - 1);

  // The state names the bit currently driven on the line.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [6:0]       r_payload,  w_payload_nxt;
  logic [2:0]       r_bit_cnt,  w_bit_cnt_nxt;
  logic [1:0]       r_stop_cnt, w_stop_cnt_nxt;
  logic [SRC_W-1:0] r_ptr,      w_ptr_nxt;
  logic [SRC_W-1:0] r_src,      w_src_nxt;
  logic [N_REQ-1:0] r_grant,    w_grant_nxt;
  logic             r_serial,   w_serial_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_done,     w_done_nxt;

  // Arbitration results
  logic             w_found;
  logic [SRC_W-1:0] w_winner;
  logic [SRC_W-1:0] w_cand;
  int               w_sum;
  logic [6:0]       w_sel_data;
  logic [N_REQ-1:0] w_onehot;

  // --------------------------------------------------------------------------
  // Round-robin search: scan from r_ptr upward, wrapping at N_REQ; the first
  // asserted request wins. A request dropped before this scan simply is not
  // seen, so nothing is remembered about it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = 0;
    w_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_cand = SRC_W'(w_sum);
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Payload mux and one-hot grant vector for the winner.
  always_comb begin
    w_sel_data = '0;
    w_onehot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == SRC_W'(i)) begin
        w_sel_data  = bus.data_in[7*i +: 7];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are computed for the state being
  // entered and then registered, so every output is glitch-free and lines up
  // with the state that owns it.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_payload_nxt  = r_payload;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_ptr_nxt      = r_ptr;
    w_src_nxt      = r_src;
    w_grant_nxt    = '0;
    w_serial_nxt   = 1'b1;
    w_busy_nxt     = 1'b1;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_found) begin
          // Payload is latched here; later data_in/req changes cannot touch
          // the frame in flight.
          w_payload_nxt = w_sel_data;
          w_src_nxt     = w_winner;
          w_grant_nxt   = w_onehot;
          w_ptr_nxt     = (int'(w_winner) == N_REQ - 1) ? '0 : w_winner + 1'b1;
          w_serial_nxt  = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_START;
        end
      end

      S_START: begin
        w_bit_cnt_nxt = 3'd0;
        w_serial_nxt  = r_payload[0];
        w_state_nxt   = S_DATA;
      end

      S_DATA: begin
        if (r_bit_cnt == 3'd6) begin
          // Odd parity: data plus parity bit carry an odd number of ones.
          w_serial_nxt = ~^r_payload;
          w_state_nxt  = S_PARITY;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          w_serial_nxt  = r_payload[r_bit_cnt + 3'd1];
        end
      end

      S_PARITY: begin
        w_stop_cnt_nxt = 2'd0;
        w_done_nxt     = (STOP_LAST == 2'd0);
        w_state_nxt    = S_STOP;
      end

      S_STOP: begin
        if (r_stop_cnt == STOP_LAST) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_stop_cnt_nxt = r_stop_cnt + 2'd1;
          w_done_nxt     = ((r_stop_cnt + 2'd1) == STOP_LAST);
        end
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. Reset aborts any frame with the line high,
  // no done pulse, and the round-robin pointer back at index 0.
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_payload  <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_ptr      <= '0;
      r_src      <= '0;
      r_grant    <= '0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_payload  <= w_payload_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_src      <= w_src_nxt;
      r_grant    <= w_grant_nxt;
      r_serial   <= w_serial_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.src        = r_src;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.serial_out = r_serial;

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the serial line (2..8).
REQ-002 Parameter: STOP_BITS, default 1, number of high stop cycles after parity (1..4).
REQ-003 Port: clk  input  1  rising-edge clock; one serial bit per cycle.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  N_REQ  per-requester frame request, level, held until granted.
REQ-006 Port: data_in  input  7*N_REQ  packed 7-bit payloads; requester i uses bits [7i+6:7i].
REQ-007 Port: grant  output  N_REQ  registered one-hot pulse, one cycle, marks payload capture.
REQ-008 Port: src  output  clog2(N_REQ)  index of the requester owning the current or last frame.
REQ-009 Port: busy  output  1  high from the grant cycle through the last stop cycle.
REQ-010 Port: done  output  1  one-cycle pulse during the last stop cycle.
REQ-011 Port: serial_out  output  1  registered serial line; idle high.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: serial_out=1 and busy=0; if any req bit is high, the arbiter SHALL select one winner per REQ-014, latch its 7-bit payload, and go to START.
REQ-014 Arbitration SHALL be round-robin: search starts at (last winner + 1) mod N_REQ and the first asserted req wins; after reset the search starts at index 0.
REQ-015 On the IDLE->START edge: grant[winner]=1 for exactly one cycle, src=winner, busy=1.
REQ-016 START: serial_out=0 for 1 cycle, then DATA.
REQ-017 DATA: serial_out=payload bit k for 7 cycles, k=0..6, LSB first, using a 3-bit counter, then PARITY.
REQ-018 PARITY: serial_out = ~^payload (odd parity: the 8 bits data+parity contain an odd number of ones) for 1 cycle, then STOP.
REQ-019 STOP: serial_out=1 for STOP_BITS cycles; done=1 in the last one; the next state is IDLE.
REQ-020 Frame latency: start bit appears 1 cycle after req is sampled in IDLE; the minimum request-to-request service period is 10+STOP_BITS cycles.
REQ-021 data_in and req changes after the grant edge SHALL NOT affect the frame in flight.
REQ-022 A req dropped before its grant SHALL be skipped without penalty; it is not remembered.
REQ-023 With all req low, the block SHALL remain in IDLE with serial_out=1 indefinitely.
REQ-024 A requester still holding req after its grant SHALL be served again only after every other asserted requester has been granted.

Reset
REQ-025 rstn low SHALL immediately, regardless of clk: state=IDLE, serial_out=1, grant=0, busy=0, done=0, src=0, RR pointer=index 0, counters=0.
REQ-026 Reset mid-frame SHALL abort the frame with the line forced high; no done pulse; the aborted requester is not re-granted automatically.

Verification
REQ-027 Single frame: req=4'b0001, data_in[6:0]=7'h41 -> grant[0] pulse; serial_out sequence 0,1,0,0,0,0,0,1,1,1 (start, data LSB first, parity=1, stop); done asserted in the stop cycle.
REQ-028 Loopback: serial_out is fed into the team receiver and three payloads 7'h00, 7'h7F, 7'h2A are sent -> receiver data_out matches each payload and parity_ok_n=0 every time.
REQ-029 Fairness: req=4'b1111 held with distinct payloads -> grants in order 0,1,2,3,0; each frame is 11 cycles apart (STOP_BITS=1); no requester is granted twice within four frames.
REQ-030 Capture: data_in[1] changes from 7'h15 to 7'h6A one cycle after grant[1] -> the transmitted payload is 7'h15.
REQ-031 Async reset: rstn pulsed low during DATA bit 3 -> serial_out=1 and busy=0 before the next clk edge; with req=4'b0100 held, the next grant is grant[2] with a full new frame.
REQ-032 Idle/parameter: STOP_BITS=3, single req -> exactly 3 high stop cycles, done in the third, then IDLE; with no req, serial_out stays 1 for 100 cycles.
